// File: rtl/framebuffer_port_arbiter.sv
// Arbitrates the single framebuffer port between the SPI host path and a
// constant-value fill engine; host has priority, bounded by a starvation limit.
module framebuffer_port_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int FB_WORDS     = 76800,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              fill_vblank_only,
    input  logic              fill_abort,
    input  logic              vblank,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              fb_wren,
    input  logic [DATA_W-1:0] fb_rdata
);
    localparam int                SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_WORDS - 1);
    localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              vblank_only_q, vblank_only_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0] fb_wdata_q, fb_wdata_d;
    logic              fb_wren_q, fb_wren_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic              fill_busy_q, fill_busy_d;
    logic              fill_done_q, fill_done_d;

    logic fill_elig, host_gnt, fill_gnt, last_word;

    // Host wins unless the fill engine has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        fill_elig = (state_q == RUN) && (remaining_q != '0) && (!vblank_only_q || vblank);
        host_gnt  = host_valid && !reset && !(fill_elig && (starve_q == STARVE_MAX));
        fill_gnt  = fill_elig && !host_gnt;
        last_word = (remaining_q == ADDR_W'(1)) || (cur_q == LAST_ADDR);
    end

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        remaining_d   = remaining_q;
        value_d       = value_q;
        vblank_only_d = vblank_only_q;
        starve_d      = starve_q;
        fb_addr_d     = fb_addr_q;
        fb_wdata_d    = fb_wdata_q;
        fb_wren_d     = 1'b0;
        rd_pend_d     = host_gnt && !host_we;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = rd_pend_q;

        if (!fill_elig || fill_gnt) begin
            starve_d = '0;
        end else if (host_gnt && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end

        if (host_gnt) begin
            fb_addr_d = host_addr;
            fb_wren_d = host_we;
            if (host_we) begin
                fb_wdata_d = host_wdata;
            end
        end else if (fill_gnt) begin
            fb_addr_d  = cur_q;
            fb_wdata_d = value_q;
            fb_wren_d  = 1'b1;
        end

        // fb_rdata answers the address registered on the previous edge.
        if (rd_pend_q) begin
            host_rdata_d = fb_rdata;
        end

        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    cur_d         = fill_addr;
                    remaining_d   = fill_len;
                    value_d       = fill_value;
                    vblank_only_d = fill_vblank_only;
                    state_d       = ((fill_len == '0) || (fill_addr > LAST_ADDR)) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (fill_gnt) begin
                    cur_d       = cur_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                end
                if (fill_abort) begin
                    state_d = IDLE;
                end else if (fill_gnt && last_word) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        fill_busy_d = (state_d != IDLE);
        fill_done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cur_q         <= '0;
            remaining_q   <= '0;
            value_q       <= '0;
            vblank_only_q <= 1'b0;
            starve_q      <= '0;
            fb_addr_q     <= '0;
            fb_wdata_q    <= '0;
            fb_wren_q     <= 1'b0;
            rd_pend_q     <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            fill_busy_q   <= 1'b0;
            fill_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            remaining_q   <= remaining_d;
            value_q       <= value_d;
            vblank_only_q <= vblank_only_d;
            starve_q      <= starve_d;
            fb_addr_q     <= fb_addr_d;
            fb_wdata_q    <= fb_wdata_d;
            fb_wren_q     <= fb_wren_d;
            rd_pend_q     <= rd_pend_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            fill_busy_q   <= fill_busy_d;
            fill_done_q   <= fill_done_d;
        end
    end

    assign host_ready  = host_gnt;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign fill_busy   = fill_busy_q;
    assign fill_done   = fill_done_q;
    assign fb_addr     = fb_addr_q;
    assign fb_wdata    = fb_wdata_q;
    assign fb_wren     = fb_wren_q;

endmodule

// File: doc/framebuffer_port_arbiter.md
Name: framebuffer_port_arbiter

Overview:
- Shares the single framebuffer RGB-index write/read port between two requesters: the SPI host command path and an internal fill engine.
- The fill engine writes a constant palette index over an address range, for example to clear the screen or fill a rectangle row.
- The host has priority. A starvation counter guarantees the fill engine forward progress.
- The block sits between spi_gpu and framebuffer, in the framebuffer port clock domain.

Parameters:
- ADDR_W, 17, framebuffer word address width.
- DATA_W, 8, palette index width.
- FB_WORDS, 76800, number of valid framebuffer words; valid addresses are 0..FB_WORDS-1.
- STARVE_LIMIT, 8, maximum consecutive host grants while a fill is waiting.

Ports:
- clk  in  1  port clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- host_valid  in  1  host access request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ready  out  1  combinational; host access accepted this cycle.
- host_rdata  out  DATA_W  read data.
- host_rvalid  out  1  read data valid, 1-cycle pulse.
- fill_start  in  1  start fill, 1-cycle pulse.
- fill_addr  in  ADDR_W  fill base address.
- fill_len  in  ADDR_W  fill word count.
- fill_value  in  DATA_W  fill index.
- fill_vblank_only  in  1  restrict fill writes to vblank.
- fill_abort  in  1  abort the running fill.
- vblank  in  1  vertical blank flag, already synchronous to clk.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  1-cycle pulse when a fill completes.
- fb_addr  out  ADDR_W  framebuffer address, registered.
- fb_wdata  out  DATA_W  framebuffer write data, registered.
- fb_wren  out  1  framebuffer write enable, registered.
- fb_rdata  in  DATA_W  framebuffer read data, 1-cycle latency after fb_addr.

Behaviour:
- Reset values: host_ready=0, host_rdata=0, host_rvalid=0, fill_busy=0, fill_done=0, fb_addr=0, fb_wdata=0, fb_wren=0. FSM goes to IDLE; the starvation counter and fill counters are cleared.
- Reset asserted mid-fill or mid-read discards all state. No done or rvalid pulse is produced afterwards.
- Fill FSM states:
  - IDLE: wait for a start.
  - RUN: fill engine is eligible for grants.
  - FINISH: one cycle, raises fill_done.
- IDLE -> RUN on fill_start. On that edge, latch cur=fill_addr, remaining=fill_len, value and vblank_only.
- fill_start with fill_len=0 or fill_addr>=FB_WORDS: go IDLE -> FINISH directly with no writes, so fill_done pulses 1 cycle after start.
- fill_start while fill_busy=1 is ignored.
- fill_busy=1 in RUN and FINISH.
- Fill eligibility (fill_elig): state==RUN, remaining!=0, and (!vblank_only or vblank).
- Arbitration each cycle, at most one grant:
  - The host is granted if host_valid and not (fill_elig and starve==STARVE_LIMIT).
  - Otherwise the fill engine is granted if fill_elig.
  - host_ready equals the host grant, computed combinationally.
- Starvation counter:
  - Increments on a host grant while fill_elig.
  - Resets to 0 on a fill grant or when !fill_elig.
  - Saturates at STARVE_LIMIT.
- Host write grant: next edge registers fb_addr=host_addr, fb_wdata=host_wdata, fb_wren=1.
- Host read grant: next edge registers fb_addr=host_addr, fb_wren=0. On the edge after that, host_rdata=fb_rdata and host_rvalid=1 for one cycle, so read latency is 2 cycles from acceptance. Back-to-back reads pipeline at one per cycle.
- Fill grant: next edge registers fb_addr=cur, fb_wdata=value, fb_wren=1; cur increments, remaining decrements.
- RUN -> FINISH when the final word is granted (remaining becomes 0), or when cur+1 would equal FB_WORDS. The end address clamps silently at FB_WORDS-1; there is no wrap to 0.
- FINISH -> IDLE after one cycle; fill_done is registered high during FINISH.
- No grant in a cycle: fb_wren=0 next cycle; fb_addr and fb_wdata hold.
- fill_abort in RUN:
  - Go to IDLE next edge with no fill_done pulse.
  - A fill grant issued in the same cycle still completes its write.
  - fill_abort has priority over FINISH entry.
  - fill_abort in IDLE or FINISH has no effect.
- fill_vblank_only=1 and vblank=0: the fill stalls in RUN with no writes and the starvation counter held at 0. The fill resumes when vblank rises.
- Simultaneous host_valid and fill_elig with starve<STARVE_LIMIT: the host wins.

Test Plan:
- Reset, then fill_start addr=100 len=4 value=0x3C with no host traffic -> fb_wren high for 4 consecutive cycles at addrs 100..103, data 0x3C; fill_done pulses 1 cycle after the last write; fill_busy falls with it.
- Host holds host_valid writes continuously during a fill of len=20 with STARVE_LIMIT=8 -> pattern of 8 host writes then 1 fill write; all 20 fill writes eventually occur; no host write is lost.
- Host read addr=5 after a fill set it to 0xAA -> host_rvalid exactly 2 cycles after host_ready with host_rdata=0xAA; 3 back-to-back reads produce 3 consecutive rvalid pulses.
- fill_addr=76798 len=10 -> writes only to 76798 and 76799, then fill_done.
- fill_len=0 -> no fb_wren; fill_done 1 cycle after start. fill_start while busy -> ignored, original range is unchanged.
- vblank_only=1 with vblank low for 50 cycles -> zero fill writes; writes begin the cycle after vblank rises.
- fill_abort after 3 of 10 writes -> exactly 3 (or 4, if a grant coincides with the abort) writes, no fill_done, fill_busy=0.
- Reset asserted mid-fill -> all outputs return to 0 immediately; no further writes occur.
